// File: rtl/spi_bus_master.sv
// Active SPI initiator: drives SS/SCLK/MOSI and samples MISO in host-commanded chunks.
// SS is active-high, MSB first, MOSI changes on SCLK fall, MISO captured on SCLK rise.
module spi_bus_master #(
  parameter int BUF_SIZE         = 9,
  parameter int CHUNK_SIZE_WIDTH = $clog2(BUF_SIZE + 1),
  parameter int SCLK_DIV         = 4,
  parameter int SS_GUARD         = 4
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  input  logic                        cmd_start,
  input  logic                        cmd_next_chunk,
  input  logic                        cmd_finish,
  input  logic [CHUNK_SIZE_WIDTH-1:0] next_chunk_size,
  input  logic [BUF_SIZE-1:0]         mosi_data,
  input  logic                        miso_in,
  output logic                        sclk_out,
  output logic                        ss_out,
  output logic                        mosi_out,
  output logic                        comm_active,
  output logic                        bus_ready,
  output logic [BUF_SIZE-1:0]         miso_data
);

  localparam int DIV_W   = $clog2(SCLK_DIV + 1);
  localparam int GUARD_W = $clog2(SS_GUARD + 1);
  localparam int BIT_W   = $clog2(BUF_SIZE + 1);

  typedef enum logic [2:0] {IDLE, SS_SETUP, READY, SHIFT, SS_HOLD} state_t;

  state_t               state_reg, state_next;
  logic [GUARD_W-1:0]   guard_reg, guard_next;
  logic [DIV_W-1:0]     div_reg, div_next;
  logic [BIT_W-1:0]     bits_reg, bits_next;
  logic                 sclk_reg, sclk_next;
  logic                 ss_reg, ss_next;
  logic [BUF_SIZE-1:0]  tx_reg, tx_next;
  logic [BUF_SIZE-1:0]  rx_reg, rx_next;
  logic [BIT_W-1:0]     chunk_len;
  logic [BUF_SIZE-1:0]  tx_load;

  // Oversized chunk requests are clamped to the buffer size.
  assign chunk_len = (32'(next_chunk_size) > BUF_SIZE) ? BIT_W'(BUF_SIZE) : BIT_W'(next_chunk_size);
  // Left-align the chunk so the next outgoing bit is always the top bit of tx_reg.
  assign tx_load   = mosi_data << (BIT_W'(BUF_SIZE) - chunk_len);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_reg <= IDLE;
      guard_reg <= '0;
      div_reg   <= '0;
      bits_reg  <= '0;
      sclk_reg  <= 1'b0;
      ss_reg    <= 1'b0;
      tx_reg    <= '0;
      rx_reg    <= '0;
    end else begin
      state_reg <= state_next;
      guard_reg <= guard_next;
      div_reg   <= div_next;
      bits_reg  <= bits_next;
      sclk_reg  <= sclk_next;
      ss_reg    <= ss_next;
      tx_reg    <= tx_next;
      rx_reg    <= rx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    guard_next = guard_reg;
    div_next   = div_reg;
    bits_next  = bits_reg;
    sclk_next  = sclk_reg;
    ss_next    = ss_reg;
    tx_next    = tx_reg;
    rx_next    = rx_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_start) begin
          state_next = SS_SETUP;
          ss_next    = 1'b1;
          guard_next = '0;
        end
      end
      SS_SETUP: begin
        if (guard_reg == GUARD_W'(SS_GUARD - 1)) state_next = READY;
        else guard_next = guard_reg + 1'b1;
      end
      READY: begin
        if (cmd_next_chunk) begin
          state_next = SHIFT;
          rx_next    = '0;
          div_next   = '0;
          sclk_next  = 1'b0;
          bits_next  = chunk_len;
          if (chunk_len != '0) tx_next = tx_load;
        end else if (cmd_finish) begin
          state_next = SS_HOLD;
          guard_next = '0;
        end
      end
      SHIFT: begin
        // bits_reg counts SCLK pulses still to complete; zero-length chunks fall straight through.
        if (bits_reg == '0) begin
          state_next = READY;
        end else if (div_reg == DIV_W'(SCLK_DIV - 1)) begin
          div_next  = '0;
          sclk_next = ~sclk_reg;
          if (!sclk_reg) begin
            rx_next = {rx_reg[BUF_SIZE-2:0], miso_in};
          end else begin
            bits_next = bits_reg - 1'b1;
            if (bits_reg == BIT_W'(1)) state_next = READY;
            else tx_next = tx_reg << 1;
          end
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
      SS_HOLD: begin
        if (guard_reg == GUARD_W'(SS_GUARD - 1)) begin
          state_next = IDLE;
          ss_next    = 1'b0;
          tx_next    = '0;
        end else begin
          guard_next = guard_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign sclk_out    = sclk_reg;
  assign ss_out      = ss_reg;
  assign comm_active = ss_reg;
  assign mosi_out    = tx_reg[BUF_SIZE-1];
  assign miso_data   = rx_reg;
  assign bus_ready   = !rst && ((state_reg == IDLE) || (state_reg == READY));

endmodule
